// File: rtl/ex_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_pkg
// Purpose  : Shared types and constants for the EX->MEM stage register.
//            Provides the occupancy state encoding, the bit positions of the
//            control word {MemRead, MemWrite, RegWrite, MemtoReg} and a
//            payload struct at the default pipeline widths.
// Revision : 1.0 - initial release
// ============================================================================
package ex_mem_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // Bit positions inside the control word, MSB first.
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  // Default pipeline widths.
  localparam int C_CTRL_W_DEF = 4;
  localparam int C_F3_W_DEF   = 3;
  localparam int C_DATA_W_DEF = 32;
  localparam int C_RD_W_DEF   = 5;

  // Payload layout at default widths; the stage declares the same layout at
  // its own parameter widths.
  typedef struct packed {
    logic [C_CTRL_W_DEF-1:0] ctrl;
    logic [C_F3_W_DEF-1:0]   funct3;
    logic [C_DATA_W_DEF-1:0] alu;
    logic [C_DATA_W_DEF-1:0] rs2;
    logic [C_RD_W_DEF-1:0]   rd;
  } ex_mem_payload_t;

  // Number of held entries for a given state.
  function automatic logic [1:0] state_occupancy(input skid_state_e s);
    case (s)
      ONE:     state_occupancy = 2'd1;
      TWO:     state_occupancy = 2'd2;
      default: state_occupancy = 2'd0;
    endcase
  endfunction

endpackage : ex_mem_pkg
`default_nettype wire

// File: rtl/ex_mem_slot.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_slot
// Purpose  : One payload holding register with load enable. Loads only when
//            i_load is high, otherwise keeps its value indefinitely.
// Ports    : clk    - clock
//            rst    - asynchronous active-high reset (clears to 0)
//            i_load - load enable
//            i_d    - payload to capture
//            o_q    - held payload
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : ex_mem_slot
`default_nettype wire

// File: rtl/ex_mem_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_skid_reg
// Purpose  : EX->MEM pipeline stage register with valid/ready handshake,
//            synchronous flush and an optional two-entry skid buffer.
//            SKID=1: main + skid entry, in_ready comes straight from a flop.
//            SKID=0: single entry, in_ready = !out_valid || out_ready.
// Ports    : clk, rst (async, active-high), flush (sync squash)
//            in_valid/in_ready + in_{ctrl,funct3,alu,rs2,rd}  : EX side
//            out_valid/out_ready + out_{ctrl,funct3,alu,rs2,rd}: MEM side
//            alu_tap   : in_alu delayed one cycle, unconditionally
//            occupancy : held entries, 0..2
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_skid_reg
  import ex_mem_pkg::*;
#(
  parameter int CTRL_W = 4,
  parameter int F3_W   = 3,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [F3_W-1:0]   in_funct3,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_rs2,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [F3_W-1:0]   out_funct3,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_rs2,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] alu_tap,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [F3_W-1:0]   funct3;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rs2;
    logic [RD_W-1:0]   rd;
  } payload_t;

  localparam int C_PW = $bits(payload_t);

  skid_state_e       r_state;
  skid_state_e       w_state_nxt;
  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_load;
  logic              w_skid_load;
  logic              w_main_from_skid;
  payload_t          w_in_pl;
  payload_t          w_main_d;
  payload_t          w_main_q;
  payload_t          w_skid_q;
  logic [DATA_W-1:0] r_alu_tap;

  assign w_in_pl = '{ctrl:   in_ctrl,
                     funct3: in_funct3,
                     alu:    in_alu,
                     rs2:    in_rs2,
                     rd:     in_rd};

  assign w_in_fire  = in_valid && w_in_ready;
  assign w_out_fire = out_valid && out_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and slot load enables. Flush overrides every transfer-in; a
  // simultaneous transfer-out still completes on the MEM side.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ONE;
            w_main_load = 1'b1;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_load = 1'b1;
          end else if (w_in_fire && (SKID != 0)) begin
            // MEM stalled while an item was in flight: park it in skid.
            w_state_nxt = TWO;
            w_skid_load = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a drain is possible.
          if (w_out_fire) begin
            w_state_nxt      = ONE;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : w_in_pl;

  // --------------------------------------------------------------------------
  // Payload slots
  // --------------------------------------------------------------------------
  ex_mem_slot #(
    .W (C_PW)
  ) u_main_slot (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_main_load),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic r_in_ready;

      ex_mem_slot #(
        .W (C_PW)
      ) u_skid_slot (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_skid_load),
        .i_d    (w_in_pl),
        .o_q    (w_skid_q)
      );

      // Registered copy of (state != TWO) so MEM back-pressure never reaches
      // in_ready through combinational logic.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_nxt != TWO);
        end
      end

      assign w_in_ready = r_in_ready;
    end else begin : g_no_skid
      assign w_skid_q   = '0;
      assign w_in_ready = !out_valid || out_ready;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Free-running ALU tap
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_tap <= '0;
    end else begin
      r_alu_tap <= in_alu;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Control bits are masked when nothing is held so a squashed or
  // drained entry cannot trigger a memory access or register write.
  // --------------------------------------------------------------------------
  assign in_ready   = w_in_ready;
  assign out_valid  = (r_state != EMPTY);
  assign out_ctrl   = out_valid ? w_main_q.ctrl : '0;
  assign out_funct3 = w_main_q.funct3;
  assign out_alu    = w_main_q.alu;
  assign out_rs2    = w_main_q.rs2;
  assign out_rd     = w_main_q.rd;
  assign alu_tap    = r_alu_tap;
  assign occupancy  = state_occupancy(r_state);

endmodule : ex_mem_skid_reg
`default_nettype wire

// File: tb/tb_ex_mem_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_skid_reg
// Purpose  : Directed self-checking bench for ex_mem_skid_reg. Drives one
//            SKID=1 and one SKID=0 instance from the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_skid_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [3:0]  in_ctrl;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu;
  logic [31:0] in_rs2;
  logic [4:0]  in_rd;

  logic        o1_in_ready, o1_out_valid;
  logic [3:0]  o1_out_ctrl;
  logic [2:0]  o1_out_funct3;
  logic [31:0] o1_out_alu, o1_out_rs2, o1_alu_tap;
  logic [4:0]  o1_out_rd;
  logic [1:0]  o1_occ;

  logic        o0_in_ready, o0_out_valid;
  logic [3:0]  o0_out_ctrl;
  logic [2:0]  o0_out_funct3;
  logic [31:0] o0_out_alu, o0_out_rs2, o0_alu_tap;
  logic [4:0]  o0_out_rd;
  logic [1:0]  o0_occ;

  int n_cmp;
  int n_err;

  ex_mem_skid_reg #(.SKID(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (o1_in_ready),
    .in_ctrl    (in_ctrl),
    .in_funct3  (in_funct3),
    .in_alu     (in_alu),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .out_valid  (o1_out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (o1_out_ctrl),
    .out_funct3 (o1_out_funct3),
    .out_alu    (o1_out_alu),
    .out_rs2    (o1_out_rs2),
    .out_rd     (o1_out_rd),
    .alu_tap    (o1_alu_tap),
    .occupancy  (o1_occ)
  );

  ex_mem_skid_reg #(.SKID(0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (o0_in_ready),
    .in_ctrl    (in_ctrl),
    .in_funct3  (in_funct3),
    .in_alu     (in_alu),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .out_valid  (o0_out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (o0_out_ctrl),
    .out_funct3 (o0_out_funct3),
    .out_alu    (o0_out_alu),
    .out_rs2    (o0_out_rs2),
    .out_rd     (o0_out_rd),
    .alu_tap    (o0_alu_tap),
    .occupancy  (o0_occ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_ctrl   = '0;
    in_funct3 = '0;
    in_alu    = '0;
    in_rs2    = '0;
    in_rd     = '0;

    // ---------------- reset (asynchronous, before any clock edge) ----------
    #1 rst = 1'b1;
    #2;
    check_eq("rst_out_valid", {63'd0, o1_out_valid}, 64'd0);
    check_eq("rst_occ",       {62'd0, o1_occ},       64'd0);
    check_eq("rst_in_ready",  {63'd0, o1_in_ready},  64'd1);
    check_eq("rst_out_ctrl",  {60'd0, o1_out_ctrl},  64'd0);
    check_eq("rst_out_alu",   {32'd0, o1_out_alu},   64'd0);
    check_eq("rst_alu_tap",   {32'd0, o1_alu_tap},   64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // ---------------- stream 4 items, out_ready=1 -------------------------
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'b1;
      in_alu    = 32'h10 + i;
      in_rd     = 5'(i + 1);
      in_ctrl   = 4'b0110;
      in_funct3 = 3'd2;
      in_rs2    = 32'hA0 + i;
      step();
      check_eq($sformatf("stream_valid_%0d", i), {63'd0, o1_out_valid}, 64'd1);
      check_eq($sformatf("stream_alu_%0d", i),   {32'd0, o1_out_alu}, 64'h10 + i);
      check_eq($sformatf("stream_rd_%0d", i),    {59'd0, o1_out_rd}, 64'(i + 1));
      check_eq($sformatf("stream_occ_%0d", i),   {62'd0, o1_occ}, 64'd1);
      check_eq($sformatf("stream_tap_%0d", i),   {32'd0, o1_alu_tap}, 64'h10 + i);
    end
    check_eq("stream_ctrl",   {60'd0, o1_out_ctrl},   64'h6);
    check_eq("stream_funct3", {61'd0, o1_out_funct3}, 64'd2);
    check_eq("stream_rs2",    {32'd0, o1_out_rs2},    64'hA3);
    check_eq("stream0_alu",   {32'd0, o0_out_alu},    64'h13);
    in_valid = 1'b0;
    step();
    check_eq("stream_drain_valid", {63'd0, o1_out_valid}, 64'd0);
    check_eq("stream_drain_occ",   {62'd0, o1_occ},       64'd0);

    // ---------------- back-pressure into skid ------------------------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_alu    = 32'h20;
    step();
    check_eq("bp_occ1",   {62'd0, o1_occ},      64'd1);
    check_eq("bp_rdy1",   {63'd0, o1_in_ready}, 64'd1);
    in_alu = 32'h21;
    step();
    check_eq("bp_occ2",   {62'd0, o1_occ},      64'd2);
    check_eq("bp_rdy2",   {63'd0, o1_in_ready}, 64'd0);
    check_eq("bp_alu2",   {32'd0, o1_out_alu},  64'h20);
    in_alu = 32'h22;
    step();
    check_eq("bp_hold_occ", {62'd0, o1_occ},     64'd2);
    check_eq("bp_hold_alu", {32'd0, o1_out_alu}, 64'h20);
    out_ready = 1'b1;
    step();
    check_eq("bp_rel_alu1", {32'd0, o1_out_alu},  64'h21);
    check_eq("bp_rel_occ1", {62'd0, o1_occ},      64'd1);
    check_eq("bp_rel_rdy1", {63'd0, o1_in_ready}, 64'd1);
    step();
    check_eq("bp_rel_alu2", {32'd0, o1_out_alu},   64'h22);
    check_eq("bp_rel_vld2", {63'd0, o1_out_valid}, 64'd1);
    in_valid = 1'b0;
    step();
    check_eq("bp_rel_empty", {63'd0, o1_out_valid}, 64'd0);

    // ---------------- flush while in TWO -----------------------------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 4'b1010;
    in_alu    = 32'h30;
    step();
    check_eq("fl_ctrl_held", {60'd0, o1_out_ctrl}, 64'hA);
    in_alu = 32'h31;
    step();
    check_eq("fl_occ_two", {62'd0, o1_occ}, 64'd2);
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    check_eq("fl_valid",   {63'd0, o1_out_valid}, 64'd0);
    check_eq("fl_ctrl",    {60'd0, o1_out_ctrl},  64'd0);
    check_eq("fl_occ",     {62'd0, o1_occ},       64'd0);
    check_eq("fl_rdy",     {63'd0, o1_in_ready},  64'd1);
    check_eq("fl_payload", {32'd0, o1_out_alu},   64'h30);

    // ---------------- flush together with transfer-in ----------------------
    in_valid = 1'b1;
    in_alu   = 32'h40;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flin_valid", {63'd0, o1_out_valid}, 64'd0);
    check_eq("flin_alu",   {32'd0, o1_out_alu},   64'h30);
    out_ready = 1'b1;
    step();
    check_eq("flin_valid2", {63'd0, o1_out_valid}, 64'd0);

    // ---------------- async reset with two entries held --------------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_alu    = 32'h50;
    step();
    in_alu = 32'h51;
    step();
    check_eq("rs_occ_two", {62'd0, o1_occ}, 64'd2);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_eq("rs_valid", {63'd0, o1_out_valid}, 64'd0);
    check_eq("rs_occ",   {62'd0, o1_occ},       64'd0);
    check_eq("rs_ctrl",  {60'd0, o1_out_ctrl},  64'd0);
    check_eq("rs_alu",   {32'd0, o1_out_alu},   64'd0);
    check_eq("rs_tap",   {32'd0, o1_alu_tap},   64'd0);
    check_eq("rs_rdy",   {63'd0, o1_in_ready},  64'd1);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_alu    = 32'h60;
    step();
    check_eq("rs_resume_alu", {32'd0, o1_out_alu}, 64'h60);
    check_eq("rs_resume_occ", {62'd0, o1_occ},     64'd1);
    in_valid = 1'b0;
    step();
    check_eq("rs_resume_empty", {63'd0, o1_out_valid}, 64'd0);

    // ---------------- SKID=0 combinational ready ---------------------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_alu    = 32'h70;
    #1;
    check_eq("s0_rdy_empty", {63'd0, o0_in_ready}, 64'd1);
    step();
    check_eq("s0_rdy_full", {63'd0, o0_in_ready}, 64'd0);
    check_eq("s0_alu",      {32'd0, o0_out_alu},  64'h70);
    check_eq("s0_occ",      {62'd0, o0_occ},      64'd1);
    in_alu = 32'h71;
    step();
    check_eq("s0_alu_stable", {32'd0, o0_out_alu},  64'h70);
    check_eq("s0_tap",        {32'd0, o0_alu_tap},  64'h71);
    check_eq("s0_rdy_stall",  {63'd0, o0_in_ready}, 64'd0);
    in_alu    = 32'h72;
    out_ready = 1'b1;
    #1;
    check_eq("s0_rdy_comb", {63'd0, o0_in_ready}, 64'd1);
    step();
    check_eq("s0_alu_next", {32'd0, o0_out_alu}, 64'h72);
    check_eq("s0_tap_next", {32'd0, o0_alu_tap}, 64'h72);
    in_valid = 1'b0;
    step();
    check_eq("s0_empty", {63'd0, o0_out_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ex_mem_skid_reg
`default_nettype wire

// File: doc/ex_mem_skid_reg.md
# ex_mem_skid_reg

Parametrised EX→MEM pipeline stage register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It replaces the single-enable stall register between execute and memory. A long-latency EX unit such as the multiplier now simply drops `in_valid` while it is busy. MEM back-pressure, for example a data-memory wait, propagates upstream through `in_ready` without a combinational path when `SKID=1`.

## Interface
- `CTRL_W`, default 4: control bits `{MemRead, MemWrite, RegWrite, MemtoReg}`, MSB first.
- `F3_W`, default 3: funct3 width.
- `DATA_W`, default 32: ALU result / RS2 data width.
- `RD_W`, default 5: destination register index width.
- `SKID`, default 1: 1 selects the two-entry skid buffer with registered `in_ready`; 0 selects a single entry with combinational `in_ready`.
- `clk` input 1: clock. Reset `rst` is asynchronous, active-high.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous squash of all held entries.
- `in_valid` input 1: EX presents a valid instruction.
- `in_ready` output 1: stage can accept this cycle.
- `in_ctrl` input CTRL_W: control bits.
- `in_funct3` input F3_W: funct3.
- `in_alu` input DATA_W: ALU result.
- `in_rs2` input DATA_W: store data.
- `in_rd` input RD_W: destination register.
- `out_valid` output 1: MEM-side entry valid.
- `out_ready` input 1: MEM consumes this cycle.
- `out_ctrl` output CTRL_W: control bits, forced to 0 whenever `out_valid`=0.
- `out_funct3` output F3_W: held payload.
- `out_alu` output DATA_W: held payload.
- `out_rs2` output DATA_W: held payload.
- `out_rd` output RD_W: held payload.
- `alu_tap` output DATA_W: `in_alu` registered every cycle, ignoring handshake and flush.
- `occupancy` output 2: number of held entries, 0..2.

## Operation
- Transfer-in occurs when `in_valid && in_ready`. Transfer-out occurs when `out_valid && out_ready`.
- State (SKID=1): EMPTY, ONE (main entry valid) or TWO (main and skid entries valid).
  - EMPTY + in → ONE, payload to main.
  - ONE + in + out → ONE, main replaced.
  - ONE + in, no out → TWO, payload to skid.
  - ONE + out, no in → EMPTY.
  - TWO + out → ONE, skid moves to main. No accept is possible because `in_ready`=0.
- `in_ready` (SKID=1) = state != TWO, driven straight from the state flop.
- SKID=0: state is only EMPTY or ONE. `in_ready = !out_valid || out_ready`.
- Payload registers load only on a write into that slot. When a slot is not written, it holds its previous value, including after being drained.
- `flush`: next state is EMPTY and any same-cycle transfer-in is discarded. Payload registers are left untouched; `out_ctrl` reads as 0 because `out_valid`=0.
- `out_valid` = state != EMPTY. `occupancy` = 0, 1 or 2 according to the state.
- All widths pass through unchanged; no arithmetic is performed.

## Timing
- Latency: 1 cycle from transfer-in to `out_valid` when the stage was EMPTY or draining. Throughput is 1 per cycle when `out_ready` is held at 1.
- Back-pressure to `in_ready` (SKID=1): `in_ready` falls the cycle after the second entry is captured. The skid entry absorbs the in-flight item, so no item is lost and none is duplicated.
- Reset: all outputs are 0 (`out_valid`, `out_ctrl`, payload, `alu_tap`, `occupancy`); state is EMPTY. `in_ready` is 1 in reset when SKID=1.
- Reset mid-operation: held entries are dropped immediately, with no drain.
- Simultaneous `flush` and `rst`: `rst` wins.
- Simultaneous `flush` and transfer-out: the transfer-out counts as completed for MEM, but the stage still becomes EMPTY.
- `alu_tap` = `in_alu` delayed by one cycle, unconditionally.

## Structure
- Package `ex_mem_pkg`:
  - `typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e`.
  - Localparams `CTRL_MEMREAD=3`, `CTRL_MEMWRITE=2`, `CTRL_REGWRITE=1`, `CTRL_MEMTOREG=0`.
  - A packed payload struct built from the parameter widths.
- Sub-module `ex_mem_slot`: one payload register with a load enable. It is instantiated once for main and, under `generate if (SKID)`, once for skid.

## Test plan
- Reset, then stream 4 items with `in_alu` = 0x10..0x13 and `out_ready`=1. Required: `out_alu` = 0x10..0x13 on consecutive cycles, 1-cycle latency, `occupancy` ≤ 1.
- SKID=1, deassert `out_ready` for 3 cycles while `in_valid`=1. Required: `occupancy` reaches 2, `in_ready`=0 one cycle after the second capture. On release, outputs appear in order with no loss and no duplicate.
- `flush` while in state TWO with `in_ctrl`=4'b1010. Required: next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0, `in_ready`=1.
- `flush` and transfer-in in the same cycle. Required: the incoming item never appears at the output.
- SKID=0 with `out_ready`=0 and `in_valid`=1. Required: `in_ready`=0 combinationally and the held payload is stable. `alu_tap` still tracks `in_alu` delayed by one cycle.
- Assert `rst` mid-stream with 2 entries held. Required: all outputs are 0 in the same cycle (async) and the stage resumes correctly after release.
